cve2_mem_arbiter: RTL and testbench
===================================

CVE2_MEM_ARBITER -- requirements
Module: cve2_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2: transactions granted but not yet answered (1..4).
REQ-002 SHALL have parameter StarveLimit, default 4: consecutive data grants allowed while instr is waiting (1..15).
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port instr_req_i, input, 1: instruction fetch request.
REQ-006 SHALL have port instr_addr_i, input, 32: fetch address.
REQ-007 SHALL have port instr_gnt_o, output, 1: fetch accepted.
REQ-008 SHALL have port instr_rvalid_o, output, 1: fetch response valid.
REQ-009 SHALL have port data_req_i, input, 1: load/store request.
REQ-010 SHALL have port data_we_i, input, 1: store when 1.
REQ-011 SHALL have port data_be_i, input, 4: byte enables.
REQ-012 SHALL have port data_addr_i, input, 32: load/store address.
REQ-013 SHALL have port data_wdata_i, input, 32: store data.
REQ-014 SHALL have port data_gnt_o, output, 1: load/store accepted.
REQ-015 SHALL have port data_rvalid_o, output, 1: load/store response valid.
REQ-016 SHALL have port rsp_rdata_o, output, 32: response data, shared by both requesters.
REQ-017 SHALL have port rsp_err_o, output, 1: response error, shared.
REQ-018 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32: shared memory request.
REQ-019 SHALL have ports mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1: shared memory handshake and response.
REQ-020 SHALL have port busy_o, output, 1: any request pending or response outstanding, for the top-level clock-gate enable.

Function
REQ-021 SHALL use a two-state FSM: ARB (choose a source combinationally) and HOLD (source locked because mem_req_o issued without mem_gnt_i).
REQ-022 In ARB, data SHALL win over instr, except that instr SHALL win when starve_cnt equals StarveLimit and instr_req_i is high.
REQ-023 starve_cnt SHALL increment on each data grant while instr_req_i is high, saturate at StarveLimit, and clear on any instr grant or when instr_req_i is low.
REQ-024 ARB->HOLD SHALL occur when mem_req_o=1 and mem_gnt_i=0; HOLD keeps the locked source and payload on mem_* until mem_gnt_i, then returns to ARB.
REQ-025 In HOLD a newly arriving higher-priority request SHALL NOT preempt the locked source.
REQ-026 mem_req_o SHALL be low while the outstanding count equals MaxOutstanding; a grant and a response in the same cycle leave the count unchanged and do not block.
REQ-027 When instr wins, mem_we_o=0, mem_be_o=4'hF and mem_wdata_o=0.
REQ-028 instr_gnt_o/data_gnt_o SHALL equal mem_gnt_i AND mem_req_o AND (source selected), same cycle; there is zero added latency.
REQ-029 Each grant SHALL push a 1-bit source tag (0 instr, 1 data) into an in-order tag FIFO; each mem_rvalid_i pops it.
REQ-030 instr_rvalid_o/data_rvalid_o SHALL equal mem_rvalid_i qualified by the FIFO head tag; rsp_rdata_o/rsp_err_o SHALL pass mem_rdata_i/mem_err_i combinationally.
REQ-031 A push and pop in the same cycle with the FIFO empty SHALL NOT occur (response needs a prior grant); with the FIFO non-empty both SHALL complete and the pointers wrap modulo MaxOutstanding.
REQ-032 mem_rvalid_i with an empty FIFO SHALL be dropped (no rvalid output) and SHALL be flagged by assertion.
REQ-033 busy_o = instr_req_i | data_req_i | (count != 0).

Reset
REQ-034 On rst_i high: FSM=ARB, starve_cnt=0, FIFO empty, count=0; while rst_i is asserted mem_req_o, grants, rvalids and busy_o SHALL be 0.
REQ-035 A reset mid-transaction SHALL discard outstanding tags; responses arriving afterwards SHALL be dropped per REQ-032.

Structure
REQ-036 The source-tag enum (ARB_SRC_INSTR/ARB_SRC_DATA) and the FSM state enum SHALL live in cve2_pkg.
REQ-037 The tag FIFO SHALL be one sub-module, cve2_arb_tag_fifo (depth MaxOutstanding, width 1).

Verification
REQ-038 Scenario: instr and data req together, mem_gnt_i always 1 -> data granted in cycle 0; the instr grant follows when data_req_i drops or after 4 data grants.
REQ-039 Scenario: data addr 0x100 issued, mem_gnt_i low for 3 cycles, instr_req_i raised in cycle 1 -> mem_addr_o stays 0x100 and no instr_gnt_o until the data grant.
REQ-040 Scenario: grants instr@0x0, data@0x200, response delay 2 -> instr_rvalid_o, then data_rvalid_o, in order, with rdata passed through.
REQ-041 Scenario: two grants outstanding, no rvalid -> mem_req_o low; rvalid and a new gnt in the same cycle -> the request is accepted.
REQ-042 Scenario: rst_i pulsed with one transaction outstanding -> outputs 0; the late mem_rvalid_i produces no rvalid output and fires the assertion.

Source files
------------

// File: rtl/cve2_pkg.sv
// cve2_pkg: shared types for the instruction/data memory arbiter.
package cve2_pkg;

    typedef enum logic {
        ARB_SRC_INSTR = 1'b0,
        ARB_SRC_DATA  = 1'b1
    } arb_src_e;

    typedef enum logic {
        ARB_ST_ARB  = 1'b0,
        ARB_ST_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

    function automatic arb_req_t instr_payload(input logic [31:0] addr);
        return '{we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0};
    endfunction

endpackage

// File: rtl/cve2_arb_tag_fifo.sv
// cve2_arb_tag_fifo: in-order source tags of granted but unanswered transactions.
module cve2_arb_tag_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  arb_src_e tag_i,
    input  logic     pop_i,
    output arb_src_e tag_o,
    output logic     empty_o,
    output logic     full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    arb_src_e        mem_q [Depth];
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign tag_o   = mem_q[rptr_q];
    // Pops on an empty FIFO are orphan responses and are ignored.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= inc(wptr_q);
            if (do_pop) rptr_q <= inc(rptr_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= tag_i;
    end
endmodule

// File: rtl/cve2_mem_arbiter.sv
// cve2_mem_arbiter: shares one memory port between instruction fetch and load/store,
// data-first with an anti-starvation limit and in-order response routing.
module cve2_mem_arbiter
    import cve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o
);
    arb_state_e state_q;
    arb_src_e   src_q, pick, src, head;
    arb_req_t   hold_q, live, cur;
    logic [3:0] starve_q;
    logic       hold, starved, gnt, rv, full, empty;

    assign hold    = (state_q == ARB_ST_HOLD);
    assign starved = instr_req_i & (starve_q == 4'(StarveLimit));
    assign pick    = (instr_req_i & (~data_req_i | starved)) ? ARB_SRC_INSTR : ARB_SRC_DATA;
    assign src     = hold ? src_q : pick;
    assign live    = (pick == ARB_SRC_INSTR) ? instr_payload(instr_addr_i)
                   : '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
    assign cur     = hold ? hold_q : live;

    // A response in the same cycle frees a slot, so a full tag FIFO does not block then.
    assign mem_req_o   = ~rst_i & (hold | instr_req_i | data_req_i) & (~full | mem_rvalid_i);
    assign mem_we_o    = cur.we;
    assign mem_be_o    = cur.be;
    assign mem_addr_o  = cur.addr;
    assign mem_wdata_o = cur.wdata;

    assign gnt         = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = gnt & (src == ARB_SRC_INSTR);
    assign data_gnt_o  = gnt & (src == ARB_SRC_DATA);

    assign rv             = ~rst_i & mem_rvalid_i & ~empty;
    assign instr_rvalid_o = rv & (head == ARB_SRC_INSTR);
    assign data_rvalid_o  = rv & (head == ARB_SRC_DATA);
    assign rsp_rdata_o    = mem_rdata_i;
    assign rsp_err_o      = mem_err_i;
    assign busy_o         = ~rst_i & (instr_req_i | data_req_i | ~empty);

    cve2_arb_tag_fifo #(.Depth(MaxOutstanding)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .tag_i   (src),
        .pop_i   (mem_rvalid_i),
        .tag_o   (head),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_ST_ARB;
            src_q    <= ARB_SRC_INSTR;
            hold_q   <= '0;
            starve_q <= '0;
        end else begin
            if (!hold && mem_req_o && !mem_gnt_i) begin
                state_q <= ARB_ST_HOLD;
                src_q   <= pick;
                hold_q  <= live;
            end else if (hold && mem_gnt_i) begin
                state_q <= ARB_ST_ARB;
            end
            starve_q <= (!instr_req_i || instr_gnt_o) ? 4'd0
                      : (data_gnt_o && !starved) ? starve_q + 4'd1 : starve_q;
        end
    end

    a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && empty))
        else $warning("cve2_mem_arbiter: response with no outstanding tag dropped");
endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// tb_cve2_mem_arbiter: directed scenario tests for the memory arbiter.
module tb_cve2_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    cve2_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin failures++; $display("FAIL rst_gnt: got %b want 00", {instr_gnt_o, data_gnt_o}); end
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL rst_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        next_cycle();
        rst_i = 0; instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        @(negedge clk);
        checks++; if ({mem_req_o, busy_o} !== 2'b00) begin failures++; $display("FAIL idle: got req/busy %b want 00", {mem_req_o, busy_o}); end
        next_cycle();
    endtask

    task automatic test_priority();
        bit exp_dg [6] = '{1, 1, 1, 1, 0, 1};
        bit exp_ig [6] = '{0, 0, 0, 0, 1, 0};
        bit exp_dr [6] = '{0, 1, 1, 1, 1, 0};
        bit exp_ir [6] = '{0, 0, 0, 0, 0, 1};
        do_reset();
        instr_addr_i = 32'h80; data_we_i = 1; data_be_i = 4'h3;
        data_addr_i = 32'h300; data_wdata_i = 32'hCAFEBABE;
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid_i = (i > 0);
            @(negedge clk);
            checks++; if (data_gnt_o !== exp_dg[i]) begin failures++; $display("FAIL prio_data_gnt[%0d]: got %b want %b", i, data_gnt_o, exp_dg[i]); end
            checks++; if (instr_gnt_o !== exp_ig[i]) begin failures++; $display("FAIL prio_instr_gnt[%0d]: got %b want %b", i, instr_gnt_o, exp_ig[i]); end
            checks++; if (data_rvalid_o !== exp_dr[i]) begin failures++; $display("FAIL prio_data_rvalid[%0d]: got %b want %b", i, data_rvalid_o, exp_dr[i]); end
            checks++; if (instr_rvalid_o !== exp_ir[i]) begin failures++; $display("FAIL prio_instr_rvalid[%0d]: got %b want %b", i, instr_rvalid_o, exp_ir[i]); end
            if (i == 4) begin
                checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h80, 32'h0})
                    begin failures++; $display("FAIL instr_payload: got we=%b be=%h addr=%h wdata=%h want 0 f 00000080 00000000", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
            end
            if (i == 0) begin
                checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'h3, 32'h300, 32'hCAFEBABE})
                    begin failures++; $display("FAIL data_payload: got we=%b be=%h addr=%h wdata=%h want 1 3 00000300 cafebabe", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
            end
            next_cycle();
        end
        do_reset();
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL drop_first_data: got %b want 1", data_gnt_o); end
        next_cycle();
        data_req_i = 0; mem_rvalid_i = 1;
        @(negedge clk);
        checks++; if ({instr_gnt_o, mem_addr_o} !== {1'b1, 32'h80}) begin failures++; $display("FAIL drop_instr_gnt: got %b/%h want 1/00000080", instr_gnt_o, mem_addr_o); end
        next_cycle();
    endtask

    task automatic test_hold();
        do_reset();
        instr_addr_i = 32'h40; data_req_i = 1; data_we_i = 1; data_be_i = 4'h3;
        data_addr_i = 32'h100; data_wdata_i = 32'hDEAD; mem_gnt_i = 0;
        @(negedge clk);
        checks++; if ({mem_req_o, data_gnt_o, mem_addr_o} !== {2'b10, 32'h100}) begin failures++; $display("FAIL hold_c0: got req=%b gnt=%b addr=%h want 1 0 00000100", mem_req_o, data_gnt_o, mem_addr_o); end
        next_cycle();
        instr_req_i = 1; data_addr_i = 32'h104;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({mem_addr_o, mem_we_o, instr_gnt_o} !== {32'h100, 2'b10}) begin failures++; $display("FAIL hold_c%0d: got addr=%h we=%b igt=%b want 00000100 1 0", i, mem_addr_o, mem_we_o, instr_gnt_o); end
            next_cycle();
        end
        mem_gnt_i = 1;
        @(negedge clk);
        checks++; if ({data_gnt_o, instr_gnt_o, mem_addr_o} !== {2'b10, 32'h100}) begin failures++; $display("FAIL hold_release: got dg=%b ig=%b addr=%h want 1 0 00000100", data_gnt_o, instr_gnt_o, mem_addr_o); end
        next_cycle();
        data_req_i = 0;
        @(negedge clk);
        checks++; if ({instr_gnt_o, mem_addr_o} !== {1'b1, 32'h40}) begin failures++; $display("FAIL hold_then_instr: got %b/%h want 1/00000040", instr_gnt_o, mem_addr_o); end
        next_cycle();
    endtask

    task automatic test_order();
        do_reset();
        instr_addr_i = 32'h0; instr_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        checks++; if ({instr_gnt_o, mem_addr_o} !== {1'b1, 32'h0}) begin failures++; $display("FAIL ord_instr_gnt: got %b/%h want 1/00000000", instr_gnt_o, mem_addr_o); end
        next_cycle();
        instr_req_i = 0; data_req_i = 1; data_we_i = 0; data_addr_i = 32'h200;
        @(negedge clk);
        checks++; if ({data_gnt_o, mem_addr_o} !== {1'b1, 32'h200}) begin failures++; $display("FAIL ord_data_gnt: got %b/%h want 1/00000200", data_gnt_o, mem_addr_o); end
        next_cycle();
        data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11111111; mem_err_i = 0;
        @(negedge clk);
        checks++; if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b101) begin failures++; $display("FAIL ord_rsp0: got ir/dr/busy=%b want 101", {instr_rvalid_o, data_rvalid_o, busy_o}); end
        checks++; if (rsp_rdata_o !== 32'h11111111) begin failures++; $display("FAIL ord_rdata0: got %h want 11111111", rsp_rdata_o); end
        next_cycle();
        mem_rdata_i = 32'h22222222; mem_err_i = 1;
        @(negedge clk);
        checks++; if ({instr_rvalid_o, data_rvalid_o, rsp_err_o} !== 3'b011) begin failures++; $display("FAIL ord_rsp1: got ir/dr/err=%b want 011", {instr_rvalid_o, data_rvalid_o, rsp_err_o}); end
        checks++; if (rsp_rdata_o !== 32'h22222222) begin failures++; $display("FAIL ord_rdata1: got %h want 22222222", rsp_rdata_o); end
        next_cycle();
        mem_rvalid_i = 0; mem_err_i = 0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ord_busy_idle: got %b want 0", busy_o); end
        next_cycle();
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        data_req_i = 1; data_we_i = 0; mem_gnt_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL lim_gnt%0d: got %b want 1", i, data_gnt_o); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if ({mem_req_o, data_gnt_o, busy_o} !== 3'b001) begin failures++; $display("FAIL lim_blocked: got req/gnt/busy=%b want 001", {mem_req_o, data_gnt_o, busy_o}); end
        next_cycle();
        mem_rvalid_i = 1;
        @(negedge clk);
        checks++; if ({mem_req_o, data_gnt_o, data_rvalid_o} !== 3'b111) begin failures++; $display("FAIL lim_gnt_rsp: got req/gnt/rv=%b want 111", {mem_req_o, data_gnt_o, data_rvalid_o}); end
        next_cycle();
        data_req_i = 0;
        @(negedge clk);
        checks++; if ({data_rvalid_o, busy_o} !== 2'b11) begin failures++; $display("FAIL lim_drain: got rv/busy=%b want 11", {data_rvalid_o, busy_o}); end
        next_cycle();
        mem_rvalid_i = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_addr_i = 32'h8; instr_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL mid_gnt: got %b want 1", instr_gnt_o); end
        next_cycle();
        rst_i = 1; data_req_i = 1;
        @(negedge clk);
        checks++; if ({mem_req_o, instr_gnt_o, data_gnt_o, busy_o} !== 4'b0000) begin failures++; $display("FAIL mid_rst_out: got req/ig/dg/busy=%b want 0000", {mem_req_o, instr_gnt_o, data_gnt_o, busy_o}); end
        next_cycle();
        rst_i = 0; instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h33;
        @(negedge clk);
        checks++; if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin failures++; $display("FAIL mid_late_rsp: got ir/dr/busy=%b want 000", {instr_rvalid_o, data_rvalid_o, busy_o}); end
        next_cycle();
        mem_rvalid_i = 0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hold();
        test_order();
        test_outstanding_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
